abs_diff_err_sweeper: RTL
=========================

Name: abs_diff_err_sweeper

Overview:
- Sequential sweep controller for a combinational approximate circuit and its exact reference; both circuits sit outside this block.
- On start, drives every input vector 0..2^IN_W-1 onto a shared bus that feeds both circuits.
- Samples the two output words, computes |exact - approx| per vector and accumulates error statistics.
- Reports pass/fail against the error threshold ET. Used in the on-chip self-check harness for synthesized approximate abs_diff variants.

Parameters:
- IN_W, 4, total input bits on the swept bus (both operands concatenated).
- OUT_W, 3, output word width of the exact and approximate circuits.
- ET, 4, maximum tolerated absolute error per vector. Must be < 2^OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep. Sampled only in IDLE.
- abort  in  1  cancel sweep. Honoured in SWEEP and DRAIN.
- vec  out  IN_W  input vector driven to both circuits.
- exact_out  in  OUT_W  exact circuit response to vec, combinational.
- approx_out  in  OUT_W  approximate circuit response to vec, combinational.
- busy  out  1  high in SWEEP or DRAIN.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  1 if max_err <= ET. Held until the next start.
- max_err  out  OUT_W  largest |exact-approx| seen.
- err_count  out  IN_W+1  number of vectors with error > ET.
- fail_valid  out  1  at least one vector has exceeded ET.
- fail_vec  out  IN_W  first vector, in sweep order, with error > ET.

Behaviour:
- Reset values (async, immediate): state=IDLE; vec=0; busy=0; done=0; pass=0; max_err=0; err_count=0; fail_valid=0; fail_vec=0; pipeline valid flags=0.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE -> SWEEP when start=1.
  - On that edge: vec<=0; max_err, err_count, fail_valid and fail_vec are cleared; pass<=0.
- SWEEP: vec increments by 1 each cycle.
  - When vec = 2^IN_W-1, the next state is DRAIN and vec holds its value. There is no wrap.
- DRAIN: lasts exactly 2 cycles, counted by an internal counter, then moves to DONE.
- DONE: done=1 for one cycle; pass <= (max_err <= ET). Then returns to IDLE.
- Pipeline stage 1: a register captures exact_out, approx_out and the vec tag on every SWEEP cycle, with valid1=1.
- Pipeline stage 2: when valid1=1, compute err = (exact>=approx) ? exact-approx : approx-exact, unsigned, OUT_W bits, with no overflow possible.
  - max_err <= max(max_err, err).
  - If err > ET: err_count increments. If fail_valid=0, then fail_vec <= tag and fail_valid <= 1.
- Latency: if start is sampled at edge k, done is high during cycle k+2^IN_W+3. All results are stable in that cycle and remain held afterwards.
- err_count is IN_W+1 bits wide so the value 2^IN_W (every vector failing) does not wrap.
- start while busy or in DONE: ignored.
- abort in SWEEP or DRAIN: next state IDLE; valid flags are cleared; done does not pulse; pass=0.
  - Partial statistics stay visible but are marked invalid by pass=0.
- abort and start together in IDLE: start wins, because abort has no effect in IDLE.
- Reset mid-sweep: all outputs return to their reset values immediately, and no done pulse is produced.

Decomposition:
- Shared package abs_diff_sweep_pkg holds:
  - the state enum {IDLE, SWEEP, DRAIN, DONE};
  - the DRAIN_CYCLES=2 constant;
  - a function for the number of sweep vectors, 2^IN_W.
- One sub-module, abs_diff_err_acc: the stage-2 abs-error compute plus the max/count/first-fail accumulators. It has clk, rst_n, clear, valid, exact, approx and tag inputs.

Test Plan:
1. approx_out tied to the exact model, ET=4 -> done at cycle k+19; max_err=0, err_count=0, fail_valid=0, pass=1.
2. approx_out forced to 0, with exact = |a-b| of 2-bit operands vec[3:2], vec[1:0], ET=2 -> max_err=3, err_count=2 (vectors 3 and 12), fail_vec=3, pass=0.
3. approx = exact+1 saturating at 7, ET=0 -> max_err=1, err_count=16, err_count does not wrap, fail_vec=0, pass=0.
4. abort asserted 5 cycles into SWEEP -> busy falls the next cycle, no done pulse, pass=0. A new start afterwards completes normally in 19 cycles.
5. start re-pulsed during SWEEP and in DONE -> ignored: vec sequence is 0..15 with no restart, and exactly one done pulse.
6. rst_n dropped mid-DRAIN -> all outputs read 0 immediately, with no clock edge needed. The next start gives correct results.

Source files
------------

// File: rtl/abs_diff_err_sweeper_pkg.sv
// Shared types and constants for the abs_diff error sweeper.
package abs_diff_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned DRAIN_CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Number of vectors in a full sweep of an in_w-bit input bus.
    function automatic int unsigned num_vectors(input int unsigned in_w);
        return 32'(1) << in_w;
    endfunction

endpackage

// File: rtl/abs_diff_err_sweeper_if.sv
// Bus between the sweep controller and the harness holding the exact/approx circuits.
interface abs_diff_err_sweeper_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3
);
    logic              start;
    logic              abort;
    logic [IN_W-1:0]   vec;
    logic [OUT_W-1:0]  exact_out;
    logic [OUT_W-1:0]  approx_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [OUT_W-1:0]  max_err;
    logic [IN_W:0]     err_count;
    logic              fail_valid;
    logic [IN_W-1:0]   fail_vec;

    modport master (
        output start, abort, exact_out, approx_out,
        input  vec, busy, done, pass, max_err, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, abort, exact_out, approx_out,
        output vec, busy, done, pass, max_err, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/abs_diff_err_acc.sv
// Stage-2 absolute-error compute with max / over-threshold count / first-fail accumulators.
module abs_diff_err_acc
    import abs_diff_sweep_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [OUT_W-1:0]  exact,
    input  logic [OUT_W-1:0]  approx,
    input  logic [IN_W-1:0]   tag,
    output logic [OUT_W-1:0]  max_err,
    output logic [IN_W:0]     err_count,
    output logic              fail_valid,
    output logic [IN_W-1:0]   fail_vec
);

    localparam logic [OUT_W-1:0] ET_W = OUT_W'(ET);

    logic [OUT_W-1:0] err_c;
    logic [OUT_W-1:0] max_err_q,    max_err_d;
    logic [IN_W:0]    err_count_q,  err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [IN_W-1:0]  fail_vec_q,   fail_vec_d;

    assign err_c = (exact >= approx) ? (exact - approx) : (approx - exact);

    // clear takes priority so a new sweep never inherits a stale sample.
    always_comb begin
        max_err_d    = max_err_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if (clear) begin
            max_err_d    = '0;
            err_count_d  = '0;
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
        end else if (valid) begin
            if (err_c > max_err_q) begin
                max_err_d = err_c;
            end
            if (err_c > ET_W) begin
                err_count_d = err_count_q + (IN_W+1)'(1);
                if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_vec_d   = tag;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_q    <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            max_err_q    <= max_err_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign max_err    = max_err_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: rtl/abs_diff_err_sweeper.sv
// Sweeps every input vector through external exact/approx circuits and grades the error.
module abs_diff_err_sweeper
    import abs_diff_sweep_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    abs_diff_err_sweeper_if.slave  bus
);

    localparam logic [IN_W-1:0]        VEC_LAST   = IN_W'(num_vectors(IN_W) - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [OUT_W-1:0]       ET_W       = OUT_W'(ET);

    state_e                 state_q,     state_d;
    logic [IN_W-1:0]        vec_q,       vec_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   pass_q,      pass_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   valid1_q,    valid1_d;
    logic [OUT_W-1:0]       ex1_q,       ex1_d;
    logic [OUT_W-1:0]       ap1_q,       ap1_d;
    logic [IN_W-1:0]        tag1_q,      tag1_d;
    logic                   acc_clear_c;
    logic [OUT_W-1:0]       acc_max_err;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        drain_cnt_d = drain_cnt_q;
        valid1_d    = 1'b0;
        ex1_d       = bus.exact_out;
        ap1_d       = bus.approx_out;
        tag1_d      = vec_q;
        acc_clear_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SWEEP;
                    vec_d       = '0;
                    pass_d      = 1'b0;
                    acc_clear_c = 1'b1;
                end
            end
            SWEEP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    valid1_d = 1'b1;
                    if (vec_q == VEC_LAST) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        vec_d = vec_q + IN_W'(1);
                    end
                end
            end
            // Two cycles let the last sample clear both pipeline stages.
            DRAIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (acc_max_err <= ET_W);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            drain_cnt_q <= '0;
            valid1_q    <= 1'b0;
            ex1_q       <= '0;
            ap1_q       <= '0;
            tag1_q      <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            drain_cnt_q <= drain_cnt_d;
            valid1_q    <= valid1_d;
            ex1_q       <= ex1_d;
            ap1_q       <= ap1_d;
            tag1_q      <= tag1_d;
        end
    end

    abs_diff_err_acc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (acc_clear_c),
        .valid      (valid1_q),
        .exact      (ex1_q),
        .approx     (ap1_q),
        .tag        (tag1_q),
        .max_err    (acc_max_err),
        .err_count  (bus.err_count),
        .fail_valid (bus.fail_valid),
        .fail_vec   (bus.fail_vec)
    );

    assign bus.vec     = vec_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.max_err = acc_max_err;

endmodule
